// File: rtl/mem_pkg.sv
// mem_pkg: load/store size encoding, responder FSM states and lane helpers.
package mem_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_ILLEGAL} mem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
  function automatic logic [3:0] byte_en(mem_size_t s, logic [1:0] a);
    return s == MEM_B ? 4'b0001 << a :
           s == MEM_H ? (a[1] ? 4'b1100 : 4'b0011) :
           s == MEM_W ? 4'b1111 : 4'b0000;
  endfunction
  // Store data comes from the low bytes; replicate it so every enabled lane sees it.
  function automatic logic [XLEN-1:0] store_lanes(mem_size_t s, logic [XLEN-1:0] d);
    return s == MEM_B ? {4{d[7:0]}} : s == MEM_H ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts the addressed byte/half/word lane and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  mem_size_t       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] sh;
  always_comb begin
    sh = word_i >> {addr_i, 3'b000};
    data_o = size_i == MEM_B ? {{24{~unsigned_i & sh[7]}}, sh[7:0]} :
             size_i == MEM_H ? {{16{~unsigned_i & sh[15]}}, sh[15:0]} :
             size_i == MEM_W ? word_i : '0;
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: M-stage load/store responder with programmable latency over a word RAM.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  resp_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, uns_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  mem_size_t size_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic accept, enter_resp, release_resp;
  logic e_wr, e_uns, e_err;
  logic [XLEN-1:0] e_addr, e_wdata, e_lanes, rd_word, ld_data;
  mem_size_t e_size;
  logic [3:0] e_be;
  logic [AW-1:0] widx;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LATENCY == 1 ? RESP : WAIT;
        cnt_d = CW'(LATENCY - 1);
      end
      WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = state_q == IDLE;
    resp_valid = state_q == RESP;
    accept = req_ready && req_valid;
    enter_resp = state_d == RESP && state_q != RESP;
    release_resp = resp_valid && resp_ready;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q <= req_write;
      addr_q <= req_addr;
      size_q <= mem_size_t'(req_size);
      uns_q <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  // With LATENCY==1 the access happens on the accept edge itself, before the latch is loaded.
  always_comb begin
    e_wr = state_q == IDLE ? req_write : wr_q;
    e_addr = state_q == IDLE ? req_addr : addr_q;
    e_size = state_q == IDLE ? mem_size_t'(req_size) : size_q;
    e_uns = state_q == IDLE ? req_unsigned : uns_q;
    e_wdata = state_q == IDLE ? req_wdata : wdata_q;
    e_err = e_size == MEM_ILLEGAL || (e_size == MEM_H && e_addr[0]) ||
            (e_size == MEM_W && e_addr[1:0] != 2'b00) || e_addr[31:2] >= DEPTH_L;
    e_be = byte_en(e_size, e_addr[1:0]);
    e_lanes = store_lanes(e_size, e_wdata);
    widx = e_addr[AW+1:2];
    rd_word = mem[widx];
  end

  mem_load_align u_align (
    .word_i    (rd_word),
    .addr_i    (e_addr[1:0]),
    .size_i    (e_size),
    .unsigned_i(e_uns),
    .data_o    (ld_data)
  );

  always_comb begin
    rdata_d = release_resp ? '0 : enter_resp ? (e_err || e_wr ? '0 : ld_data) : rdata_q;
    err_d = release_resp ? 1'b0 : enter_resp ? e_err : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && e_wr && !e_err)
      for (int i = 0; i < 4; i++)
        if (e_be[i]) mem[widx][8*i +: 8] <= e_lanes[8*i +: 8];
  end

  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for two responders (LATENCY 2 and 4).
module tb_data_memory_responder;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  localparam int LAT [2] = '{2, 4};
  logic clk = 1'b0;
  logic [1:0] rst, req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0] req_ready, resp_valid, resp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata [2];
  logic [1:0] req_size [2];
  exp_t sb [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                     input bit u, input logic [31:0] wd, input logic [31:0] er, input bit ee,
                     input int hold = 0);
    int n;
    exp_t e;
    @(negedge clk);
    chk("req_ready", 32'(req_ready[d]), 1);
    req_write[d] = wr;
    req_addr[d] = a;
    req_size[d] = sz;
    req_unsigned[d] = u;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    sb.push_back('{er, ee});
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d] = $urandom;
    req_wdata[d] = $urandom;
    n = 1;
    while (!resp_valid[d] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, LAT[d]);
    e = sb.pop_front();
    chk("rdata", resp_rdata[d], e.rdata);
    chk("err", 32'(resp_err[d]), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid[d]), 1);
      chk("hold_rdata", resp_rdata[d], e.rdata);
      chk("hold_ready", 32'(req_ready[d]), 0);
    end
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    chk("idle_ready", 32'(req_ready[d]), 1);
    chk("idle_valid", 32'(resp_valid[d]), 0);
    chk("idle_rdata", resp_rdata[d], 0);
    chk("idle_err", 32'(resp_err[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 2'b11;
    req_valid = '0;
    req_write = '0;
    req_unsigned = '0;
    resp_ready = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0;
      req_wdata[i] = '0;
      req_size[i] = 2'b10;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 2'b00;
    #1;
    chk("rst_ready", 32'(req_ready[0]), 1);
    chk("rst_valid", 32'(resp_valid[0]), 0);
    chk("rst_rdata", resp_rdata[0], 0);
    chk("rst_err", 32'(resp_err[0]), 0);
    txn(0, 1, 32'h10, 2'b10, 0, 32'h8000_00F1, 0, 0);
    txn(0, 0, 32'h10, 2'b10, 0, 0, 32'h8000_00F1, 0);
    txn(0, 0, 32'h10, 2'b00, 0, 0, 32'hFFFF_FFF1, 0);
    txn(0, 0, 32'h10, 2'b00, 1, 0, 32'h0000_00F1, 0);
    txn(0, 0, 32'h12, 2'b01, 0, 0, 32'hFFFF_8000, 0);
    txn(0, 0, 32'h12, 2'b01, 1, 0, 32'h0000_8000, 0);
    txn(0, 1, 32'h11, 2'b00, 0, 32'h1234_565A, 0, 0);
    txn(0, 0, 32'h10, 2'b10, 0, 0, 32'h8000_5AF1, 0);
    txn(0, 0, 32'h13, 2'b10, 0, 0, 0, 1);
    txn(0, 1, 32'h11, 2'b01, 0, 32'h0000_FFFF, 0, 1);
    txn(0, 0, 32'h10, 2'b11, 0, 0, 0, 1);
    txn(0, 1, 32'h10, 2'b11, 0, 32'hFFFF_FFFF, 0, 1);
    txn(0, 0, 32'h10, 2'b10, 0, 0, 32'h8000_5AF1, 0);
    txn(0, 1, 32'h0, 2'b10, 0, 32'h0BAD_F00D, 0, 0);
    txn(0, 0, 32'h1000, 2'b10, 0, 0, 0, 1);
    txn(0, 1, 32'h1000, 2'b10, 0, 32'h1111_1111, 0, 1);
    txn(0, 0, 32'h0, 2'b10, 0, 0, 32'h0BAD_F00D, 0);
    txn(0, 1, 32'h12, 2'b01, 0, 32'h0000_BEEF, 0, 0);
    txn(0, 0, 32'h10, 2'b10, 0, 0, 32'hBEEF_5AF1, 0, 5);
    txn(0, 0, 32'h13, 2'b00, 0, 0, 32'hFFFF_FFBE, 0);
    txn(1, 1, 32'h20, 2'b10, 0, 32'h1234_5678, 0, 0);
    @(negedge clk);
    req_write[1] = 1'b1;
    req_addr[1] = 32'h20;
    req_size[1] = 2'b10;
    req_wdata[1] = 32'hDEAD_BEEF;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("wait_valid", 32'(resp_valid[1]), 0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("drop_valid", 32'(resp_valid[1]), 0);
      chk("drop_ready", 32'(req_ready[1]), 1);
    end
    txn(1, 0, 32'h20, 2'b10, 0, 0, 32'h1234_5678, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
